// File: rtl/bcd_tick_counter.sv
// Single-digit BCD up/down counter with a prescaled auto-advance timebase,
// single-step on step rising edge, parallel load and a decimal-point flag for the segment decoder.
module bcd_tick_counter #(
  parameter int PRESCALE  = 10000000,
  parameter int PRE_W     = 24,
  parameter int MAX_DIGIT = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       run,
  input  logic       up,
  input  logic       step,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] digit,
  output logic       tick,
  output logic       wrap,
  output logic       dp
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [PRE_W-1:0] PRE_ZERO = {PRE_W{1'b0}};
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
  localparam logic [3:0]       MAX_D    = 4'(MAX_DIGIT);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [3:0]       digit_q, digit_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic             dp_q, dp_d;
  logic             step_q;

  logic             step_rise_s;
  logic             auto_adv_s;
  logic             adv_s;
  logic             at_limit_s;

  // Prescaler next state and automatic-advance strobe; a load restarts the period.
  always_comb begin
    step_rise_s = step & ~step_q;
    auto_adv_s  = 1'b0;
    pre_d       = pre_q;
    if (ena) begin
      if (load) begin
        pre_d = PRE_ZERO;
      end else if (run) begin
        if (pre_q == PRE_LAST) begin
          pre_d      = PRE_ZERO;
          auto_adv_s = 1'b1;
        end else begin
          pre_d = pre_q + PRE_ONE;
        end
      end else begin
        pre_d = pre_q;
      end
    end else begin
      pre_d = pre_q;
    end
  end

  // Digit next state with load > advance > hold; a coincident auto tick and step edge advance once.
  always_comb begin
    adv_s      = auto_adv_s | step_rise_s;
    at_limit_s = up ? (digit_q == MAX_D) : (digit_q == 4'd0);
    digit_d    = digit_q;
    tick_d     = 1'b0;
    wrap_d     = 1'b0;
    dp_d       = dp_q;
    if (!ena) begin
      digit_d = digit_q;
    end else if (load) begin
      digit_d = (load_val > MAX_D) ? MAX_D : load_val;
    end else if (adv_s) begin
      tick_d = auto_adv_s;
      if (at_limit_s) begin
        digit_d = up ? 4'd0 : MAX_D;
        wrap_d  = 1'b1;
        dp_d    = ~dp_q;
      end else begin
        digit_d = up ? (digit_q + 4'd1) : (digit_q - 4'd1);
      end
    end else begin
      digit_d = digit_q;
    end
  end

  // State registers; step_q tracks step even while disabled and resets high to swallow a held step.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q   <= PRE_ZERO;
      digit_q <= 4'd0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      dp_q    <= 1'b0;
      step_q  <= 1'b1;
    end else begin
      pre_q   <= pre_d;
      digit_q <= digit_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      dp_q    <= dp_d;
      step_q  <= step;
    end
  end

  assign digit = digit_q;
  assign tick  = tick_q;
  assign wrap  = wrap_q;
  assign dp    = dp_q;

endmodule
